// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store responder for the RISC-V core.
// Ports: req* from execute (valid/ready), mem* single-outstanding byte-lane
// data bus, rsp* one-cycle writeback pulse (data, regwrite, fault).
// Optional MEM_TIMEOUT_EN: abort a bus cycle after TimeoutCycles stalls.
module mem_access_unit #(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqStore,
  input  logic [2:0]           reqFunc3,
  input  logic [AddrWidth-1:0] reqAddr,
  input  logic [DataWidth-1:0] reqData,
  output logic                 memValid,
  input  logic                 memReady,
  output logic                 memWriteEnable,
  output logic [3:0]           memByteEnable,
  output logic [AddrWidth-1:0] memAddr,
  output logic [DataWidth-1:0] memWriteData,
  input  logic [DataWidth-1:0] memReadData,
  output logic                 rspValid,
  output logic                 rspRegWrite,
  output logic [DataWidth-1:0] rspData,
  output logic                 rspFault
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t state;

  logic [2:0] lat_func3;
  logic [1:0] lat_off;
  logic       lat_store;

  logic                 legal;
  logic                 aligned;
  logic [3:0]           be;
  logic [DataWidth-1:0] wdata;
  logic [DataWidth-1:0] load_val;
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;

  assign reqReady = (state == IDLE);

  // request decode
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b0;
    be      = 4'b0000;
    wdata   = reqData;
    if (reqStore) begin
      legal = (reqFunc3 == 3'd0) ||
              (reqFunc3 == 3'd1) ||
              (reqFunc3 == 3'd2);
    end else begin
      legal = (reqFunc3 == 3'd0) ||
              (reqFunc3 == 3'd1) ||
              (reqFunc3 == 3'd2) ||
              (reqFunc3 == 3'd4) ||
              (reqFunc3 == 3'd5);
    end
    unique case (1'b1)
      (reqFunc3[1:0] == 2'd0): begin
        aligned = 1'b1;
        be      = 4'b0001 << reqAddr[1:0];
        wdata   = {4{reqData[7:0]}};
      end
      (reqFunc3[1:0] == 2'd1): begin
        aligned = ~reqAddr[0];
        be      = 4'b0011 << {reqAddr[1], 1'b0};
        wdata   = {2{reqData[15:0]}};
      end
      default: begin
        aligned = (reqAddr[1:0] == 2'b00);
        be      = 4'b1111;
        wdata   = reqData;
      end
    endcase
  end

  // load lane extraction and extension
  always_comb begin
    rd_byte = memReadData[8*lat_off +: 8];
    rd_half = lat_off[1] ? memReadData[31:16]
                         : memReadData[15:0];
    unique case (lat_func3)
      3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
      3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
      3'd4:    load_val = {24'd0, rd_byte};
      3'd5:    load_val = {16'd0, rd_half};
      default: load_val = memReadData;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  logic [CntW-1:0]      cnt;
  logic [AddrWidth-1:0] lat_addr;
`else
  logic timeout_unused;
  assign timeout_unused = (TimeoutCycles != 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lat_func3      <= 3'd0;
      lat_off        <= 2'd0;
      lat_store      <= 1'b0;
      memValid       <= 1'b0;
      memWriteEnable <= 1'b0;
      memByteEnable  <= 4'b0000;
      memAddr        <= '0;
      memWriteData   <= '0;
      rspValid       <= 1'b0;
      rspRegWrite    <= 1'b0;
      rspData        <= '0;
      rspFault       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt            <= '0;
      lat_addr       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (reqValid) begin
            lat_func3 <= reqFunc3;
            lat_off   <= reqAddr[1:0];
            lat_store <= reqStore;
`ifdef MEM_TIMEOUT_EN
            lat_addr  <= reqAddr;
            cnt       <= '0;
`endif
            if (legal && aligned) begin
              state          <= BUS;
              memValid       <= 1'b1;
              memWriteEnable <= reqStore;
              memByteEnable  <= be;
              memAddr        <= {reqAddr[AddrWidth-1:2], 2'b00};
              memWriteData   <= reqStore ? wdata : '0;
            end else begin
              // faults skip the bus entirely
              state       <= RESP;
              rspValid    <= 1'b1;
              rspFault    <= 1'b1;
              rspRegWrite <= 1'b0;
              rspData     <= DataWidth'(reqAddr);
            end
          end
        end
        BUS: begin
          if (memReady) begin
            state          <= RESP;
            memValid       <= 1'b0;
            memWriteEnable <= 1'b0;
            memByteEnable  <= 4'b0000;
            memAddr        <= '0;
            memWriteData   <= '0;
            rspValid       <= 1'b1;
            rspFault       <= 1'b0;
            rspRegWrite    <= ~lat_store;
            rspData        <= lat_store ? '0 : load_val;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt == CntLast) begin
            state          <= RESP;
            memValid       <= 1'b0;
            memWriteEnable <= 1'b0;
            memByteEnable  <= 4'b0000;
            memAddr        <= '0;
            memWriteData   <= '0;
            rspValid       <= 1'b1;
            rspFault       <= 1'b1;
            rspRegWrite    <= 1'b0;
            rspData        <= DataWidth'(lat_addr);
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          state       <= IDLE;
          rspValid    <= 1'b0;
          rspFault    <= 1'b0;
          rspRegWrite <= 1'b0;
          rspData     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// Drives/samples 1ns after each rising edge; immediate asserts per check.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqStore;
  logic [2:0]  reqFunc3;
  logic [31:0] reqAddr;
  logic [31:0] reqData;
  logic        memValid;
  logic        memReady;
  logic        memWriteEnable;
  logic [3:0]  memByteEnable;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic        rspValid;
  logic        rspRegWrite;
  logic [31:0] rspData;
  logic        rspFault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk            (clk),
    .reset          (reset),
    .reqValid       (reqValid),
    .reqReady       (reqReady),
    .reqStore       (reqStore),
    .reqFunc3       (reqFunc3),
    .reqAddr        (reqAddr),
    .reqData        (reqData),
    .memValid       (memValid),
    .memReady       (memReady),
    .memWriteEnable (memWriteEnable),
    .memByteEnable  (memByteEnable),
    .memAddr        (memAddr),
    .memWriteData   (memWriteData),
    .memReadData    (memReadData),
    .rspValid       (rspValid),
    .rspRegWrite    (rspRegWrite),
    .rspData        (rspData),
    .rspFault       (rspFault)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a request for one accept edge, then drop reqValid
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    reqValid = 1'b1;
    reqStore = st;
    reqFunc3 = f3;
    reqAddr  = a;
    reqData  = d;
    tick();
    reqValid = 1'b0;
  endtask

  // complete a load with data rd in the first BUS cycle
  task automatic load_now(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] rd,
                          input logic [3:0] ebe,
                          input logic [31:0] eval);
    issue(1'b0, f3, a, 32'h0);
    chk({tag, "_mv"}, 32'(memValid), 32'd1);
    chk({tag, "_be"}, 32'(memByteEnable), 32'(ebe));
    chk({tag, "_addr"}, memAddr, {a[31:2], 2'b00});
    memReady    = 1'b1;
    memReadData = rd;
    tick();
    memReady = 1'b0;
    chk({tag, "_rv"}, 32'(rspValid), 32'd1);
    chk({tag, "_rw"}, 32'(rspRegWrite), 32'd1);
    chk({tag, "_data"}, rspData, eval);
    chk({tag, "_flt"}, 32'(rspFault), 32'd0);
    tick();
    chk({tag, "_rv0"}, 32'(rspValid), 32'd0);
    chk({tag, "_rdy"}, 32'(reqReady), 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    reqValid    = 1'b0;
    reqStore    = 1'b0;
    reqFunc3    = 3'd0;
    reqAddr     = 32'h0;
    reqData     = 32'h0;
    memReady    = 1'b0;
    memReadData = 32'h0;
    tick();
    chk("rst_mv", 32'(memValid), 32'd0);
    chk("rst_be", 32'(memByteEnable), 32'd0);
    chk("rst_rv", 32'(rspValid), 32'd0);
    chk("rst_rd", rspData, 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_rdy", 32'(reqReady), 32'd1);

    // lw basic
    load_now("lw", 3'd2, 32'h100, 32'hDEADBEEF,
             4'b1111, 32'hDEADBEEF);
    // byte / half extraction
    load_now("lb", 3'd0, 32'h103, 32'h80FF0000,
             4'b1000, 32'hFFFFFF80);
    load_now("lbu", 3'd4, 32'h103, 32'h80FF0000,
             4'b1000, 32'h00000080);
    load_now("lh", 3'd1, 32'h102, 32'h80FF0000,
             4'b1100, 32'hFFFF80FF);
    load_now("lhu", 3'd5, 32'h102, 32'h80FF0000,
             4'b1100, 32'h000080FF);
    load_now("lb1", 3'd0, 32'h101, 32'h0000_7F00,
             4'b0010, 32'h0000007F);

    // sh with 3-cycle stall; a faulting lw is held meanwhile
    issue(1'b1, 3'd1, 32'h202, 32'h1234ABCD);
    reqValid = 1'b1;
    reqStore = 1'b0;
    reqFunc3 = 3'd2;
    reqAddr  = 32'h101;
    for (int i = 0; i < 4; i++) begin
      chk("sh_mv", 32'(memValid), 32'd1);
      chk("sh_we", 32'(memWriteEnable), 32'd1);
      chk("sh_wd", memWriteData, 32'hABCDABCD);
      chk("sh_be", 32'(memByteEnable), 32'b1100);
      chk("sh_addr", memAddr, 32'h200);
      chk("sh_rdy", 32'(reqReady), 32'd0);
      if (i == 3) memReady = 1'b1;
      tick();
    end
    memReady = 1'b0;
    chk("sh_rv", 32'(rspValid), 32'd1);
    chk("sh_rw", 32'(rspRegWrite), 32'd0);
    chk("sh_data", rspData, 32'd0);
    chk("sh_flt", 32'(rspFault), 32'd0);
    chk("held_rdy0", 32'(reqReady), 32'd0);
    tick();
    chk("held_rdy", 32'(reqReady), 32'd1);
    chk("sh_rv0", 32'(rspValid), 32'd0);
    tick();
    reqValid = 1'b0;
    chk("mis_mv", 32'(memValid), 32'd0);
    chk("mis_rv", 32'(rspValid), 32'd1);
    chk("mis_flt", 32'(rspFault), 32'd1);
    chk("mis_rw", 32'(rspRegWrite), 32'd0);
    chk("mis_data", rspData, 32'h101);
    tick();
    chk("mis_rv0", 32'(rspValid), 32'd0);
    chk("mis_flt0", 32'(rspFault), 32'd0);

    // illegal store func3
    issue(1'b1, 3'd4, 32'h40, 32'h0);
    chk("ill_mv", 32'(memValid), 32'd0);
    chk("ill_flt", 32'(rspFault), 32'd1);
    chk("ill_data", rspData, 32'h40);
    tick();

    // misaligned halfword store
    issue(1'b1, 3'd1, 32'h33, 32'h0);
    chk("msh_mv", 32'(memValid), 32'd0);
    chk("msh_flt", 32'(rspFault), 32'd1);
    chk("msh_data", rspData, 32'h33);
    tick();

    // sb lane replication
    issue(1'b1, 3'd0, 32'h1, 32'hFFFF_FF5A);
    chk("sb_wd", memWriteData, 32'h5A5A5A5A);
    chk("sb_be", 32'(memByteEnable), 32'b0010);
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    chk("sb_rv", 32'(rspValid), 32'd1);
    chk("sb_rw", 32'(rspRegWrite), 32'd0);
    tick();

    // reset during BUS
    issue(1'b0, 3'd2, 32'h10, 32'h0);
    chk("rb_mv1", 32'(memValid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rb_mv0", 32'(memValid), 32'd0);
    memReady    = 1'b1;
    memReadData = 32'hCAFEF00D;
    tick();
    chk("rb_rv", 32'(rspValid), 32'd0);
    reset = 1'b0;
    tick();
    chk("rb_rv2", 32'(rspValid), 32'd0);
    chk("rb_mv2", 32'(memValid), 32'd0);
    memReady = 1'b0;
    load_now("rb_lw", 3'd2, 32'h104, 32'h11223344,
             4'b1111, 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
